// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit front end.
//   Issues sequential fetch requests (pc += 4), holds at most DEPTH requests
//   in flight plus buffered, pushes in-order responses into a DEPTH-entry
//   {inst, pc} FIFO, and presents the FIFO head to decode. A backend flush
//   or a predicted-taken head being accepted by decode redirects fetch; any
//   responses still in flight at that point are counted and discarded.
// Ports:
//   i_clk, i_rstn                      clock, synchronous active-low reset
//   o_ifetch_req_valid/_addr, i_ifetch_req_ready   fetch request channel
//   i_ifetch_rsp_valid/_inst           in-order fetch response (always accepted)
//   o_dec_valid/_inst/_pc/_prdt_taken, i_dec_ready decode handshake
//   i_prdt_taken, i_prdt_pc            combinational prediction for the head
//   i_flush, i_flush_pc                backend redirect
`ifndef XLEN
`define XLEN 32
`endif

module ifu_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int               DEPTH    = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic              o_ifetch_req_valid,
  input  logic              i_ifetch_req_ready,
  output logic [`XLEN-1:0]  o_ifetch_req_addr,
  input  logic              i_ifetch_rsp_valid,
  input  logic [31:0]       i_ifetch_rsp_inst,
  output logic              o_dec_valid,
  input  logic              i_dec_ready,
  output logic [31:0]       o_dec_inst,
  output logic [`XLEN-1:0]  o_dec_pc,
  output logic              o_dec_prdt_taken,
  input  logic              i_prdt_taken,
  input  logic [`XLEN-1:0]  i_prdt_pc,
  input  logic              i_flush,
  input  logic [`XLEN-1:0]  i_flush_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [`XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]    outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [31:0]      inst_q [DEPTH];
  logic [`XLEN-1:0] ipc_q  [DEPTH];

  logic rsp, dec_fire, req_fire, redir_tk, redirect, push, pop;
  logic [`XLEN-1:0] target;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A response with nothing outstanding can only be a stale one from before
  // reset; ignore it so the counters never underflow.
  assign rsp       = i_ifetch_rsp_valid & (outst_q != '0);
  assign o_dec_valid = i_rstn & (cnt_q != '0);
  assign dec_fire  = o_dec_valid & i_dec_ready;
  assign redir_tk  = dec_fire & i_prdt_taken & ~i_flush;
  assign redirect  = i_flush | redir_tk;
  assign target    = i_flush ? i_flush_pc : i_prdt_pc;

  // Request only while every in-flight response is guaranteed a FIFO slot.
  assign o_ifetch_req_valid = i_rstn & ~i_flush & ~redir_tk &
                              (({1'b0, outst_q} + {1'b0, cnt_q}) < (CW + 1)'(DEPTH));
  assign o_ifetch_req_addr  = pc_q;
  assign req_fire = o_ifetch_req_valid & i_ifetch_req_ready;

  assign push = rsp & (drop_q == '0) & ~redirect;
  assign pop  = dec_fire & ~redirect;

  assign o_dec_inst       = inst_q[rp_q];
  assign o_dec_pc         = ipc_q[rp_q];
  assign o_dec_prdt_taken = i_prdt_taken & o_dec_valid;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    outst_d  = outst_q + CW'(req_fire) - CW'(rsp);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wp_d     = push ? nxt(wp_q) : wp_q;
    rp_d     = pop  ? nxt(rp_q) : rp_q;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d     = target;
      rsp_pc_d = target;
      drop_d   = outst_d;
      cnt_d    = '0;
      wp_d     = '0;
      rp_d     = '0;
    end else begin
      if (req_fire) pc_d = pc_q + `XLEN'(4);
      if (rsp) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              rsp_pc_d = rsp_pc_q + `XLEN'(4);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      if (push) begin
        inst_q[wp_q] <= i_ifetch_rsp_inst;
        ipc_q[wp_q]  <= rsp_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        i_clk = 0, i_rstn = 0;
  logic        o_ifetch_req_valid, i_ifetch_req_ready = 0;
  logic [31:0] o_ifetch_req_addr;
  logic        i_ifetch_rsp_valid = 0;
  logic [31:0] i_ifetch_rsp_inst = 0;
  logic        o_dec_valid, i_dec_ready = 0;
  logic [31:0] o_dec_inst, o_dec_pc;
  logic        o_dec_prdt_taken, i_prdt_taken = 0;
  logic [31:0] i_prdt_pc = 0;
  logic        i_flush = 0;
  logic [31:0] i_flush_pc = 0;

  ifu_fetch dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .o_ifetch_req_valid(o_ifetch_req_valid), .i_ifetch_req_ready(i_ifetch_req_ready),
    .o_ifetch_req_addr(o_ifetch_req_addr),
    .i_ifetch_rsp_valid(i_ifetch_rsp_valid), .i_ifetch_rsp_inst(i_ifetch_rsp_inst),
    .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready),
    .o_dec_inst(o_dec_inst), .o_dec_pc(o_dec_pc), .o_dec_prdt_taken(o_dec_prdt_taken),
    .i_prdt_taken(i_prdt_taken), .i_prdt_pc(i_prdt_pc),
    .i_flush(i_flush), .i_flush_pc(i_flush_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int cyc = 0, last_due = 0;
  int nchk = 0, npass = 0;

  // stimulus applied at the next negedge
  logic s_rstn = 0, s_rdy = 1, s_drdy = 1, s_tk = 0, s_flush = 0, tk_en = 0;
  logic [31:0] s_ppc = 0, s_fpc = 0, tk_pc = 0;
  int s_lat = 1;
  // observations of the last cycle
  logic ob_rv, ob_rf, ob_dv, ob_df, ob_dtk, ap_tk, ap_fl;
  logic [31:0] ob_ra, ob_dpc, ob_dinst;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cycle();
    int due;
    @(negedge i_clk);
    i_rstn = s_rstn;
    if (!s_rstn) begin mq.delete(); last_due = 0; end
    if (s_rstn && mq.size() > 0 && mq[0].due <= cyc) begin
      i_ifetch_rsp_valid = 1; i_ifetch_rsp_inst = f(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      i_ifetch_rsp_valid = 0; i_ifetch_rsp_inst = $urandom;
    end
    i_ifetch_req_ready = s_rdy; i_dec_ready = s_drdy; i_prdt_pc = s_ppc;
    i_flush = s_flush; i_flush_pc = s_fpc; i_prdt_taken = s_tk;
    #1;
    // simple predictor: taken when the head sits at tk_pc
    if (tk_en && o_dec_valid && o_dec_pc == tk_pc) i_prdt_taken = 1;
    #1;
    ob_rv = o_ifetch_req_valid; ob_ra = o_ifetch_req_addr;
    ob_rf = o_ifetch_req_valid & i_ifetch_req_ready;
    ob_dv = o_dec_valid; ob_dpc = o_dec_pc; ob_dinst = o_dec_inst;
    ob_df = o_dec_valid & i_dec_ready; ob_dtk = o_dec_prdt_taken;
    ap_tk = i_prdt_taken; ap_fl = i_flush;
    if (ob_rf) begin
      due = cyc + s_lat;
      if (due <= last_due) due = last_due + 1;
      mq.push_back('{addr: ob_ra, due: due});
      last_due = due;
    end
    cyc++;
  endtask

  task automatic set_idle();
    s_rdy = 1; s_drdy = 1; s_tk = 0; s_flush = 0; tk_en = 0;
    s_ppc = 0; s_fpc = 0; tk_pc = 0; s_lat = 1;
  endtask

  task automatic do_reset();
    s_rstn = 0; cycle(); cycle(); s_rstn = 1;
  endtask

  task automatic test_reset();
    set_idle(); s_tk = 1;
    s_rstn = 0; cycle(); cycle();
    nchk++; if (ob_rv !== 1'b0) $display("FAIL rst_req_valid got %b want 0", ob_rv); else npass++;
    nchk++; if (ob_dv !== 1'b0) $display("FAIL rst_dec_valid got %b want 0", ob_dv); else npass++;
    nchk++; if (ob_dtk !== 1'b0) $display("FAIL rst_prdt_taken got %b want 0", ob_dtk); else npass++;
    s_rstn = 1; s_tk = 0; cycle();
    nchk++; if (ob_rv !== 1'b1) $display("FAIL first_req_valid got %b want 1", ob_rv); else npass++;
    nchk++; if (ob_ra !== RPC) $display("FAIL first_req_addr got %h want %h", ob_ra, RPC); else npass++;
  endtask

  task automatic test_straight();
    logic [31:0] er = RPC, ed = RPC;
    int nd = 0;
    set_idle(); do_reset();
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (ob_rf) begin
        nchk++; if (ob_ra !== er) $display("FAIL straight_req got %h want %h", ob_ra, er); else npass++;
        er += 4;
      end
      if (ob_df) begin
        nchk++; if (ob_dpc !== ed) $display("FAIL straight_dec_pc got %h want %h", ob_dpc, ed); else npass++;
        nchk++; if (ob_dinst !== f(ed)) $display("FAIL straight_dec_inst got %h want %h", ob_dinst, f(ed)); else npass++;
        ed += 4; nd++;
      end
    end
    nchk++; if (nd < 10) $display("FAIL straight_throughput got %0d want >=10", nd); else npass++;
  endtask

  task automatic test_backpressure();
    int nr = 0;
    bit found = 0;
    set_idle(); s_drdy = 0; do_reset();
    for (int i = 0; i < 8; i++) begin cycle(); if (ob_rf) nr++; end
    nchk++; if (nr != 2) $display("FAIL bp_req_count got %0d want 2", nr); else npass++;
    nchk++; if (ob_rv !== 1'b0) $display("FAIL bp_req_valid got %b want 0", ob_rv); else npass++;
    nchk++; if (ob_dv !== 1'b1 || ob_dpc !== RPC)
      $display("FAIL bp_head got v=%b pc=%h want v=1 pc=%h", ob_dv, ob_dpc, RPC); else npass++;
    s_drdy = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (ob_rf) begin
        found = 1;
        nchk++; if (ob_ra !== RPC + 8) $display("FAIL bp_resume_addr got %h want %h", ob_ra, RPC + 8); else npass++;
      end
    end
    if (!found) begin nchk++; $display("FAIL bp_resume timeout got none want %h", RPC + 8); end
  endtask

  task automatic test_taken();
    bit fr = 0, fd = 0;
    set_idle(); s_lat = 3; s_drdy = 0; tk_en = 1; tk_pc = RPC + 4; s_ppc = RPC + 32'h100;
    do_reset();
    for (int i = 0; i < 8; i++) cycle();
    s_drdy = 1; cycle();
    nchk++; if (!ob_df || ob_dpc !== RPC || ob_dtk !== 1'b0)
      $display("FAIL tk_dec0 got f=%b pc=%h tk=%b want f=1 pc=%h tk=0", ob_df, ob_dpc, ob_dtk, RPC); else npass++;
    s_drdy = 0; cycle();
    nchk++; if (!ob_rf || ob_ra !== RPC + 8)
      $display("FAIL tk_req8 got f=%b a=%h want f=1 a=%h", ob_rf, ob_ra, RPC + 8); else npass++;
    s_drdy = 1; cycle();
    nchk++; if (!ob_df || ob_dpc !== RPC + 4 || ob_dtk !== 1'b1)
      $display("FAIL tk_branch got f=%b pc=%h tk=%b want f=1 pc=%h tk=1", ob_df, ob_dpc, ob_dtk, RPC + 4); else npass++;
    nchk++; if (ob_rv !== 1'b0) $display("FAIL tk_req_gate got %b want 0", ob_rv); else npass++;
    tk_en = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ob_rf && !fr) begin
        fr = 1;
        nchk++; if (ob_ra !== RPC + 32'h100) $display("FAIL tk_target_req got %h want %h", ob_ra, RPC + 32'h100); else npass++;
      end
      if (ob_df && !fd) begin
        fd = 1;
        nchk++; if (ob_dpc !== RPC + 32'h100) $display("FAIL tk_target_dec got %h want %h", ob_dpc, RPC + 32'h100); else npass++;
      end
    end
    if (!fr || !fd) begin nchk++; $display("FAIL tk_target timeout got r=%b d=%b want 1 1", fr, fd); end
  endtask

  task automatic test_flush_taken();
    bit fr = 0, fd = 0;
    set_idle(); s_drdy = 0; do_reset();
    for (int i = 0; i < 6; i++) cycle();
    s_drdy = 1; tk_en = 1; tk_pc = RPC; s_ppc = RPC + 32'h100; s_flush = 1; s_fpc = RPC + 32'h200;
    cycle();
    nchk++; if (ob_rv !== 1'b0) $display("FAIL ft_req_gate got %b want 0", ob_rv); else npass++;
    tk_en = 0; s_flush = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ob_rf && !fr) begin
        fr = 1;
        nchk++; if (ob_ra !== RPC + 32'h200) $display("FAIL ft_req got %h want %h", ob_ra, RPC + 32'h200); else npass++;
      end
      if (ob_df && !fd) begin
        fd = 1;
        nchk++; if (ob_dpc !== RPC + 32'h200) $display("FAIL ft_dec got %h want %h", ob_dpc, RPC + 32'h200); else npass++;
      end
    end
    if (!fr || !fd) begin nchk++; $display("FAIL ft timeout got r=%b d=%b want 1 1", fr, fd); end
  endtask

  task automatic test_flush_outstanding();
    int nr = 0;
    bit fr = 0, fd = 0;
    set_idle(); s_lat = 3; do_reset();
    cycle(); if (ob_rf) nr++;
    cycle(); if (ob_rf) nr++;
    nchk++; if (nr != 2) $display("FAIL fo_inflight got %0d want 2", nr); else npass++;
    s_flush = 1; s_fpc = RPC + 32'h300; cycle();
    nchk++; if (ob_rv !== 1'b0) $display("FAIL fo_req_gate got %b want 0", ob_rv); else npass++;
    s_flush = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (ob_rf && !fr) begin
        fr = 1;
        nchk++; if (ob_ra !== RPC + 32'h300) $display("FAIL fo_req got %h want %h", ob_ra, RPC + 32'h300); else npass++;
      end
      if (ob_df && !fd) begin
        fd = 1;
        nchk++; if (ob_dpc !== RPC + 32'h300) $display("FAIL fo_dec got %h want %h", ob_dpc, RPC + 32'h300); else npass++;
      end
    end
    if (!fr || !fd) begin nchk++; $display("FAIL fo timeout got r=%b d=%b want 1 1", fr, fd); end
  endtask

  task automatic test_reset_mid();
    bit fd = 0;
    set_idle(); do_reset();
    for (int i = 0; i < 6; i++) cycle();
    s_rstn = 0; s_tk = 1; cycle();
    nchk++; if (ob_rv !== 1'b0) $display("FAIL rm_req_valid got %b want 0", ob_rv); else npass++;
    nchk++; if (ob_dv !== 1'b0) $display("FAIL rm_dec_valid got %b want 0", ob_dv); else npass++;
    nchk++; if (ob_dtk !== 1'b0) $display("FAIL rm_prdt_taken got %b want 0", ob_dtk); else npass++;
    cycle();
    s_rstn = 1; s_tk = 0; cycle();
    nchk++; if (ob_rv !== 1'b1 || ob_ra !== RPC)
      $display("FAIL rm_first_req got v=%b a=%h want v=1 a=%h", ob_rv, ob_ra, RPC); else npass++;
    for (int i = 0; i < 10 && !fd; i++) begin
      cycle();
      if (ob_df) begin
        fd = 1;
        nchk++; if (ob_dpc !== RPC) $display("FAIL rm_first_dec got %h want %h", ob_dpc, RPC); else npass++;
      end
    end
    if (!fd) begin nchk++; $display("FAIL rm_dec timeout got none want %h", RPC); end
  endtask

  // Reference: the decode stream is the program-order pc sequence; each
  // accepted head is followed by its predicted target if taken, else pc+4,
  // and a flush restarts both streams at the flush target.
  task automatic test_random();
    logic [31:0] er = RPC, ed = RPC;
    int nd = 0;
    set_idle(); do_reset();
    for (int i = 0; i < 600; i++) begin
      s_rdy   = ($urandom % 4) != 0;
      s_drdy  = ($urandom % 3) != 0;
      s_tk    = ($urandom % 8) == 0;
      s_ppc   = RPC | (32'($urandom_range(0, 4095)) << 2);
      s_flush = ($urandom % 20) == 0;
      s_fpc   = RPC | (32'($urandom_range(0, 4095)) << 2);
      s_lat   = $urandom_range(1, 4);
      cycle();
      if (ob_rf) begin
        nchk++; if (ob_ra !== er) $display("FAIL rnd_req cyc=%0d got %h want %h", cyc, ob_ra, er); else npass++;
        er += 4;
      end
      if (ob_df) begin
        nd++;
        nchk++; if (ob_dpc !== ed) $display("FAIL rnd_dec_pc cyc=%0d got %h want %h", cyc, ob_dpc, ed); else npass++;
        nchk++; if (ob_dinst !== f(ed)) $display("FAIL rnd_dec_inst cyc=%0d got %h want %h", cyc, ob_dinst, f(ed)); else npass++;
        nchk++; if (ob_dtk !== ap_tk) $display("FAIL rnd_dec_tk cyc=%0d got %b want %b", cyc, ob_dtk, ap_tk); else npass++;
      end
      nchk++; if (mq.size() > 2) $display("FAIL rnd_inflight cyc=%0d got %0d want <=2", cyc, mq.size()); else npass++;
      if (ap_fl) begin er = s_fpc; ed = s_fpc; end
      else if (ob_df && ap_tk) begin er = s_ppc; ed = s_ppc; end
      else if (ob_df) ed += 4;
    end
    nchk++; if (nd < 50) $display("FAIL rnd_progress got %0d want >=50", nd); else npass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_taken();
    test_flush_taken();
    test_flush_outstanding();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
